// File: rtl/bus_router.sv
// Address-decoding bus router: one transaction at a time, sync/handshaked slaves, timeout, sticky irq.
// Latency 1 cycle on decode miss, 3+ cycles on hit; the master holds its request until the m_ready pulse.
module bus_router #(
  parameter int                 NSLV     = 8,
  parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hf0000000}},
  parameter logic [NSLV-1:0]    SLV_SYNC = {NSLV{1'b0}},
  parameter int                 TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        m_a,
  input  logic [31:0]        m_d,
  input  logic               m_we,
  input  logic               m_rd,
  output logic [31:0]        m_spo,
  output logic               m_ready,
  output logic               m_err,
  output logic [NSLV*32-1:0] s_a,
  output logic [31:0]        s_d,
  output logic [NSLV-1:0]    s_we,
  output logic [NSLV-1:0]    s_rd,
  input  logic [NSLV*32-1:0] s_spo,
  input  logic [NSLV-1:0]    s_ready,
  input  logic               err_clr,
  output logic [31:0]        err_addr,
  output logic               irq
);

  localparam int HW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     lat_a, lat_d;
  logic            lat_we;
  logic [HW-1:0]   hit;
  logic [15:0]     cnt;
  logic [31:0]     spo_q;
  logic            err_q;
  logic            dec_hit;
  logic [HW-1:0]   dec_idx;
  logic            fin_ok, fin_err;
  logic            sel_sync, sel_ready;
  logic [31:0]     sel_spo;

  // Descending scan so the lowest matching channel index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_a & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
        dec_hit = 1'b1;
        dec_idx = HW'(i);
      end
    end
  end

  assign sel_sync  = SLV_SYNC[hit];
  assign sel_ready = s_ready[hit];
  assign sel_spo   = s_spo[{hit, 5'b0} +: 32];

  always_comb begin
    state_nxt = state;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: begin
        if (m_we | m_rd) begin
          state_nxt = dec_hit ? ISSUE : DONE;
          fin_err   = !dec_hit;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (sel_sync || sel_ready) begin
          state_nxt = DONE;
          fin_ok    = 1'b1;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state_nxt = DONE;
          fin_err   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a    <= '0;
      lat_d    <= '0;
      lat_we   <= 1'b0;
      hit      <= '0;
      cnt      <= '0;
      spo_q    <= '0;
      err_q    <= 1'b0;
      irq      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (state == IDLE && (m_we | m_rd)) begin
        lat_a  <= m_a;
        lat_d  <= m_d;
        lat_we <= m_we;
        hit    <= dec_idx;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 16'd1;
      // Response registers are non-zero only during DONE.
      spo_q <= (fin_ok && !lat_we) ? sel_spo : '0;
      err_q <= fin_err;
      if (fin_err) begin
        irq      <= 1'b1;
        err_addr <= (state == IDLE) ? m_a : lat_a;
      end else if (err_clr) begin
        irq <= 1'b0;
      end
    end
  end

  always_comb begin
    s_we = '0;
    s_rd = '0;
    if (state == ISSUE) begin
      if (lat_we) s_we[hit] = 1'b1;
      else        s_rd[hit] = 1'b1;
    end
  end

  for (genvar g = 0; g < NSLV; g++) begin : g_off
    assign s_a[g*32 +: 32] = lat_a & ~SLV_MASK[g*32 +: 32];
  end

  assign s_d     = lat_d;
  assign m_spo   = spo_q;
  assign m_err   = err_q;
  assign m_ready = (state == DONE);

endmodule

// File: tb/tb_bus_router.sv
// Scoreboard bench for bus_router: expectations queued at request time, checked on each m_ready.
module tb_bus_router;

  localparam int NSLV = 8;

  logic               clk, rst_n;
  logic [31:0]        m_a, m_d, m_spo, err_addr;
  logic               m_we, m_rd, m_ready, m_err, err_clr, irq;
  logic [NSLV*32-1:0] s_a, s_spo;
  logic [31:0]        s_d;
  logic [NSLV-1:0]    s_we, s_rd, s_ready, mrdy, force_rdy;

  bus_router #(
    .NSLV    (NSLV),
    .SLV_BASE({32'h80000000, 32'h70000000, 32'h60000000, 32'h50000000,
               32'h40000000, 32'h20000000, 32'h40000000, 32'h92000000}),
    .SLV_MASK({32'hf0000000, 32'hf0000000, 32'hf0000000, 32'hf0000000,
               32'hff000000, 32'hf0000000, 32'hf0000000, 32'hff000000}),
    .SLV_SYNC(8'b0000_0001),
    .TIMEOUT (16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
    .m_spo(m_spo), .m_ready(m_ready), .m_err(m_err), .s_a(s_a), .s_d(s_d),
    .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
    .err_clr(err_clr), .err_addr(err_addr), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] chan_spo(input int i);
    return (i == 0) ? 32'hA5A5A5A5 : (32'hC0DE0000 | 32'(i));
  endfunction

  for (genvar g = 0; g < NSLV; g++) begin : g_spo
    assign s_spo[g*32 +: 32] = chan_spo(g);
  end
  assign s_ready = mrdy | force_rdy;

  // Handshaked slave model: ready rises in WAIT cycle dly[i]; ch2 also glitches ready during ISSUE.
  int wc[NSLV];
  bit armed[NSLV];
  int dly[NSLV]    = '{0, 0, 4, 0, 1000, 0, 0, 0};
  bit glitch[NSLV] = '{0, 0, 1, 0, 0, 0, 0, 0};
  initial mrdy = '0;
  always @(negedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (!rst_n || m_ready) begin
        armed[i] = 0;
        mrdy[i]  = 1'b0;
      end else if (s_we[i] | s_rd[i]) begin
        armed[i] = 1;
        wc[i]    = 0;
        mrdy[i]  = glitch[i];
      end else if (armed[i]) begin
        mrdy[i] = (wc[i] == dly[i]);
        wc[i]++;
      end
    end
  end

  typedef struct {
    logic [31:0] d, spo, soff;
    int          lat, start;
    logic        err;
    logic [7:0]  wm, rm;
  } exp_t;
  exp_t sb[$];

  logic [7:0] acc_we, acc_rd;
  int         n_strobe;
  initial begin acc_we = '0; acc_rd = '0; n_strobe = 0; end

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_we = '0; acc_rd = '0; n_strobe = 0;
    end else begin
      if (|s_we || |s_rd) begin
        n_strobe++;
        acc_we |= s_we;
        acc_rd |= s_rd;
        if (sb.size() > 0) begin
          for (int i = 0; i < NSLV; i++)
            if (s_we[i] | s_rd[i]) chk("s_a", s_a[i*32 +: 32], sb[0].soff);
          chk("s_d", s_d, sb[0].d);
        end
      end
      if (m_ready) begin
        if (sb.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
          chk("m_spo", m_spo, e.spo);
          chk("m_err", 32'(m_err), 32'(e.err));
          chk("we_mask", 32'(acc_we), 32'(e.wm));
          chk("rd_mask", 32'(acc_rd), 32'(e.rm));
          chk("n_strobe", 32'(n_strobe), ((e.wm | e.rm) != 0) ? 32'd1 : 32'd0);
        end
        acc_we = '0; acc_rd = '0; n_strobe = 0;
      end
    end
  end

  // Returns at the negedge inside DONE, with the request already dropped.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rd,
                     input int lat, input logic [31:0] spo, input logic err,
                     input logic [7:0] wm, input logic [7:0] rm, input logic [31:0] soff);
    exp_t e;
    int   n;
    @(negedge clk);
    e.d = d; e.spo = spo; e.soff = soff; e.lat = lat; e.start = cyc;
    e.err = err; e.wm = wm; e.rm = rm;
    sb.push_back(e);
    m_a = a; m_d = d; m_we = we; m_rd = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ready && n < 100);
    if (!m_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    m_we = 1'b0; m_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int late;
    rst_n = 1'b0; m_a = '0; m_d = '0; m_we = 1'b0; m_rd = 1'b0;
    err_clr = 1'b0; force_rdy = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 0);
    chk("rst_m_err", 32'(m_err), 0);
    chk("rst_m_spo", m_spo, 0);
    chk("rst_strobes", 32'({s_we, s_rd}), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_s_a0", s_a[31:0], 0);
    chk("rst_s_d", s_d, 0);
    rst_n = 1'b1;

    // Sync read, sync write, handshaked write (ready in 5th WAIT cycle), handshaked read.
    txn(32'h92000014, 32'h0, 1'b0, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 8'h00, 8'h01, 32'h00000014);
    chk("sync_rd_irq", 32'(irq), 0);
    txn(32'h92000020, 32'h12345678, 1'b1, 1'b0, 3, 32'h0, 1'b0, 8'h01, 8'h00, 32'h00000020);
    txn(32'h20000100, 32'hDEADBEEF, 1'b1, 1'b0, 7, 32'h0, 1'b0, 8'h04, 8'h00, 32'h00000100);
    txn(32'h4A000008, 32'h0, 1'b0, 1'b1, 3, 32'hC0DE0001, 1'b0, 8'h00, 8'h02, 32'h0A000008);

    // Decode miss, irq clear, then clear coinciding with a new error.
    txn(32'h30000000, 32'h0, 1'b0, 1'b1, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    chk("miss_irq", 32'(irq), 1);
    chk("miss_err_addr", err_addr, 32'h30000000);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_irq", 32'(irq), 0);
    chk("clr_err_addr_held", err_addr, 32'h30000000);
    err_clr = 1'b1;
    txn(32'h30000040, 32'h0, 1'b1, 1'b0, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    chk("set_wins_irq", 32'(irq), 1);
    chk("set_wins_addr", err_addr, 32'h30000040);
    err_clr = 1'b0;
    @(negedge clk);
    chk("irq_sticky", 32'(irq), 1);

    // Timeout on a channel whose ready never rises.
    txn(32'h50000004, 32'h0, 1'b0, 1'b1, 18, 32'h0, 1'b1, 8'h00, 8'h10, 32'h00000004);
    chk("tmo_irq", 32'(irq), 1);
    chk("tmo_err_addr", err_addr, 32'h50000004);

    // Channels 1 and 3 both match; write wins over read; lowest channel wins.
    txn(32'h40000010, 32'hCAFEF00D, 1'b1, 1'b1, 3, 32'h0, 1'b0, 8'h02, 8'h00, 32'h00000010);

    // Back-to-back mixed traffic.
    for (int j = 0; j < 6; j++) begin
      int          ch;
      logic [31:0] off, base;
      logic        we;
      ch   = j % 3;
      off  = 32'($urandom_range(0, 255)) << 2;
      we   = (j % 2 == 0);
      base = (ch == 0) ? 32'h92000000 : (ch == 1) ? 32'h40000000 : 32'h20000000;
      txn(base | off, 32'h1000 + 32'(j), we, !we, (ch == 2) ? 7 : 3,
          we ? 32'h0 : chan_spo(ch), 1'b0,
          we ? 8'(1 << ch) : 8'h00, we ? 8'h00 : 8'(1 << ch), off);
    end

    // Reset during WAIT, then a late ready must not complete anything.
    @(negedge clk);
    m_a = 32'h50000000; m_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_ready", 32'(m_ready), 0);
    chk("mid_rst_strobes", 32'({s_we, s_rd}), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_err_addr", err_addr, 0);
    m_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    force_rdy = 8'h10;
    late = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_ready) late++;
    end
    force_rdy = '0;
    chk("late_ready_count", 32'(late), 0);
    txn(32'h92000004, 32'h0, 1'b0, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 8'h00, 8'h01, 32'h00000004);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
